// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD segment scanner.
package lcd_pkg;

   typedef logic [1:0] lcd_h_t;

   localparam int LCD_SEGMENTS   = 16;
   localparam int LCD_H_COUNT    = 4;
   localparam int LCD_FRAME_BITS = 128;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_COMMIT
   } lcd_state_t;

   function automatic logic [6:0] lcd_index(
      input lcd_h_t     h,
      input logic       b_sel,
      input logic [3:0] seg
   );
      return {h, b_sel, seg};
   endfunction

endpackage

// File: rtl/lcd_persist_cell.sv
// One frame bit: working sample plus persistence counter.
module lcd_persist_cell #(
   parameter int PERSIST_FRAMES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic sample_en,
   input  logic sample_bit,
   input  logic commit,
   output logic filtered
);

   localparam int CW = $clog2(PERSIST_FRAMES + 1);

   logic          work;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work <= 1'b0;
         cnt  <= '0;
      end else begin
         if (sample_en)
            work <= sample_bit;
         if (commit) begin
            if (work)
               cnt <= CW'(PERSIST_FRAMES);
            else if (cnt != '0)
               cnt <= cnt - CW'(1);
         end
      end
   end

   assign filtered = (cnt != '0);

endmodule

// File: rtl/lcd_scanner.sv
// Scans the 4 LCD common lines, filters flicker, publishes a 128-bit frame.
module lcd_scanner
   import lcd_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 2,
   parameter int PERSIST_FRAMES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        lcd_tick,
   input  logic        lcd_enable,
   output logic [1:0]  lcd_h,
   input  logic [15:0] segment_a,
   input  logic [15:0] segment_b,
   input  logic [6:0]  rd_addr,
   output logic        rd_data,
   output logic        frame_done,
   output logic        busy
);

   lcd_state_t state, state_n;
   logic [3:0] cnt, cnt_n;
   lcd_h_t     h_n;
   logic       sample;
   logic       commit;

   logic [LCD_FRAME_BITS-1:0] filtered;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         lcd_h      <= '0;
         frame_done <= 1'b0;
         rd_data    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         lcd_h      <= h_n;
         frame_done <= commit;
         rd_data    <= filtered[rd_addr];
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      h_n     = lcd_h;
      sample  = 1'b0;
      commit  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (lcd_tick) begin
               state_n = ST_SETTLE;
               cnt_n   = 4'(SETTLE_CYCLES - 1);
            end
         end
         ST_SETTLE: begin
            if (cnt == 4'd0)
               state_n = ST_SAMPLE;
            else
               cnt_n = cnt - 4'd1;
         end
         ST_SAMPLE: begin
            sample = 1'b1;
            if (lcd_h == 2'd3) begin
               state_n = ST_COMMIT;
            end else begin
               h_n     = lcd_h + 2'd1;
               state_n = ST_IDLE;
            end
         end
         ST_COMMIT: begin
            commit  = 1'b1;
            h_n     = '0;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   // Cell i maps to {h, b_sel, seg} = i, so only block lcd_h is written.
   for (genvar i = 0; i < LCD_FRAME_BITS; i++) begin : g_cell
      localparam lcd_h_t CH  = lcd_h_t'(i / (2 * LCD_SEGMENTS));
      localparam int     SEG = i % LCD_SEGMENTS;
      localparam bit     BSEL = ((i / LCD_SEGMENTS) % 2) == 1;

      logic raw;
      logic wr;

      assign raw = BSEL ? segment_b[SEG] : segment_a[SEG];
      assign wr  = sample && (lcd_h == CH);

      lcd_persist_cell #(
         .PERSIST_FRAMES(PERSIST_FRAMES)
      ) u_cell (
         .clk       (clk),
         .reset     (reset),
         .sample_en (wr),
         .sample_bit(raw & lcd_enable),
         .commit    (commit),
         .filtered  (filtered[i])
      );
   end

endmodule

// File: tb/tb_lcd_scanner.sv
// Directed self-checking bench for lcd_scanner.
module tb_lcd_scanner;
   import lcd_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        lcd_tick;
   logic        lcd_enable;
   logic [1:0]  lcd_h;
   logic [15:0] segment_a;
   logic [15:0] segment_b;
   logic [6:0]  rd_addr;
   logic        rd_data;
   logic        frame_done;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int fd_cnt = 0;

   logic [15:0] fa[4];
   logic [15:0] fb[4];

   lcd_scanner #(
      .SETTLE_CYCLES (2),
      .PERSIST_FRAMES(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .lcd_tick  (lcd_tick),
      .lcd_enable(lcd_enable),
      .lcd_h     (lcd_h),
      .segment_a (segment_a),
      .segment_b (segment_b),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .frame_done(frame_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (frame_done) fd_cnt++;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [6:0] a,
                     input logic exp);
      rd_addr = a;
      @(negedge clk);
      chk(tag, 32'(rd_data), 32'(exp));
   endtask

   // One H scan; returns with the FSM in IDLE (or COMMIT for H=3).
   task automatic scan(input int h, input logic en);
      chk($sformatf("lcd_h_before_scan%0d", h), 32'(lcd_h), 32'(h));
      segment_a  = fa[h];
      segment_b  = fb[h];
      lcd_enable = en;
      lcd_tick   = 1'b1;
      @(negedge clk);
      lcd_tick = 1'b0;
      repeat (3) @(negedge clk);
      segment_a  = 16'h0;
      segment_b  = 16'h0;
      lcd_enable = ~en;
   endtask

   task automatic frame(input string tag, input logic en);
      int fd0;
      fd0 = fd_cnt;
      for (int h = 0; h < 4; h++) scan(h, en);
      chk({tag, "_commit_busy"}, 32'(busy), 32'd1);
      chk({tag, "_fd_early"}, 32'(frame_done), 32'd0);
      @(negedge clk);
      chk({tag, "_fd_pulse"}, 32'(frame_done), 32'd1);
      chk({tag, "_lcd_h_wrap"}, 32'(lcd_h), 32'd0);
      @(negedge clk);
      chk({tag, "_fd_count"}, 32'(fd_cnt - fd0), 32'd1);
   endtask

   task automatic clear_tab();
      for (int h = 0; h < 4; h++) begin
         fa[h] = 16'h0;
         fb[h] = 16'h0;
      end
   endtask

   logic [0:16] bexp;
   int          hexp[17];
   int          bad;

   initial begin
      reset      = 1'b1;
      lcd_tick   = 1'b0;
      lcd_enable = 1'b1;
      segment_a  = 16'h0;
      segment_b  = 16'h0;
      rd_addr    = 7'd0;
      clear_tab();
      repeat (3) @(negedge clk);
      chk("rst_lcd_h", 32'(lcd_h), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      chk("rst_rd", 32'(rd_data), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Frame 1: a0 at H0, seg5 A at H1, b15 at H2
      fa[0] = 16'h0001;
      fa[1] = 16'h0020;
      fb[2] = 16'h8000;
      frame("f1", 1'b1);
      rd("f1_idx0", lcd_index(2'd0, 1'b0, 4'd0), 1'b1);
      rd("f1_idx16", 7'd16, 1'b0);
      rd("f1_idx95", lcd_index(2'd2, 1'b1, 4'd15), 1'b1);
      rd("f1_idx31", 7'd31, 1'b0);
      rd("f1_idx127", 7'd127, 1'b0);
      rd("f1_idx37", 7'd37, 1'b1);
      rd("f1_idx1", 7'd1, 1'b0);

      // Frames 2 and 3 dark: persistence decays 2 -> 1 -> 0
      clear_tab();
      frame("f2", 1'b1);
      rd("f2_idx37", 7'd37, 1'b1);
      rd("f2_idx95", 7'd95, 1'b1);
      frame("f3", 1'b1);
      rd("f3_idx37", 7'd37, 1'b0);
      rd("f3_idx0", 7'd0, 1'b0);

      // Enable low during sampling masks everything
      for (int h = 0; h < 4; h++) begin
         fa[h] = 16'hFFFF;
         fb[h] = 16'hFFFF;
      end
      frame("fen0", 1'b0);
      bad = 0;
      for (int i = 0; i < 128; i++) begin
         rd_addr = 7'(i);
         @(negedge clk);
         if (rd_data !== 1'b0) bad++;
      end
      chk("fen0_all_zero_bits", 32'(bad), 32'd0);

      // Tick held high: back-to-back scans
      clear_tab();
      bexp = 17'b1110_1110_1110_1111_0;
      hexp = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 0};
      lcd_tick = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         chk($sformatf("hold_busy%0d", i), 32'(busy), 32'(bexp[i]));
         chk($sformatf("hold_h%0d", i), 32'(lcd_h), 32'(hexp[i]));
      end
      lcd_tick = 1'b0;
      chk("hold_fd", 32'(frame_done), 32'd1);
      @(negedge clk);
      chk("hold_idle", 32'(busy), 32'd0);

      // All-lit frame, then reset mid-SETTLE at H=2
      for (int h = 0; h < 4; h++) begin
         fa[h] = 16'hFFFF;
         fb[h] = 16'hFFFF;
      end
      frame("flit", 1'b1);
      rd("flit_idx0", 7'd0, 1'b1);
      rd("flit_idx127", 7'd127, 1'b1);
      scan(0, 1'b1);
      scan(1, 1'b1);
      chk("pre_rst_h", 32'(lcd_h), 32'd2);
      lcd_tick = 1'b1;
      @(negedge clk);
      lcd_tick = 1'b0;
      chk("settle_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_h", 32'(lcd_h), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_fd", 32'(frame_done), 32'd0);
      chk("mid_rst_rd", 32'(rd_data), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      rd("post_rst_idx0", 7'd0, 1'b0);
      rd("post_rst_idx64", 7'd64, 1'b0);
      rd("post_rst_idx127", 7'd127, 1'b0);

      clear_tab();
      fa[0] = 16'h0003;
      fb[3] = 16'h0004;
      frame("frec", 1'b1);
      rd("frec_idx0", 7'd0, 1'b1);
      rd("frec_idx1", 7'd1, 1'b1);
      rd("frec_idx2", 7'd2, 1'b0);
      rd("frec_idx32", 7'd32, 1'b0);
      rd("frec_idx114", lcd_index(2'd3, 1'b1, 4'd2), 1'b1);
      rd("frec_idx64", 7'd64, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
